// File: rtl/spi_master_sequencer.sv
// Command-queue front end for spi_master: queues commands, issues them over start_trans/busy, returns masked rx words.
// Build option SPI_SEQ_RSP_FIFO_EN selects a RSP_DEPTH response FIFO; otherwise a single response holding register.
module spi_master_sequencer #(
    parameter int SLAVE_ADDRS_LEN = 3,
    parameter int CMD_DEPTH       = 4,
    parameter int RSP_DEPTH       = 4,
    parameter int TIMEOUT         = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [31:0]                  cmd_data,
    input  logic [SLAVE_ADDRS_LEN-1:0]   cmd_addr,
    input  logic [1:0]                   cmd_len,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_data,
    output logic [SLAVE_ADDRS_LEN-1:0]   rsp_addr,
    output logic                         start_trans,
    input  logic                         m_busy,
    output logic [31:0]                  m_tx_data,
    output logic [SLAVE_ADDRS_LEN-1:0]   m_chipADDRS,
    output logic [1:0]                   m_transaction_length,
    input  logic [31:0]                  m_rx_data,
    output logic [$clog2(CMD_DEPTH):0]   cmd_count,
    output logic                         err_timeout
);
    localparam int CW = $clog2(CMD_DEPTH);
    localparam int EW = SLAVE_ADDRS_LEN + 34;
    localparam int RE = SLAVE_ADDRS_LEN + 32;
    localparam logic [CW:0] CMD_FULL = (CW+1)'(CMD_DEPTH);
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, SETTLE, CAPTURE} state_t;

    logic [EW-1:0] cmd_mem_q [CMD_DEPTH];
    logic [CW:0]   cmd_wr_ptr_q, cmd_wr_ptr_d, cmd_rd_ptr_q, cmd_rd_ptr_d, cmd_count_q, cmd_count_d;
    logic          cmd_avail_q, cmd_avail_d;
    state_t        state_q, state_d;
    logic          start_q, start_d;
    logic [31:0]   tx_q, tx_d;
    logic [SLAVE_ADDRS_LEN-1:0] addr_q, addr_d;
    logic [1:0]    len_q, len_d;
    logic [7:0]    tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          cmd_push, cmd_pop, rsp_push, rsp_pop, rsp_free;
    logic [EW-1:0] cmd_head;
    logic [31:0]   rx_mask, rx_masked;

    assign cmd_ready            = (cmd_count_q != CMD_FULL);
    assign cmd_count            = cmd_count_q;
    assign start_trans          = start_q;
    assign m_tx_data            = tx_q;
    assign m_chipADDRS          = addr_q;
    assign m_transaction_length = len_q;
    assign err_timeout          = err_q;
    assign rsp_pop              = rsp_valid && rsp_ready;

    always_comb begin
        cmd_push  = cmd_valid && cmd_ready;
        cmd_head  = cmd_mem_q[cmd_rd_ptr_q[CW-1:0]];
        cmd_pop   = 1'b0;
        rsp_push  = 1'b0;
        state_d   = state_q;
        start_d   = 1'b0;
        tx_d      = tx_q;
        addr_d    = addr_q;
        len_d     = len_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_avail_q && (cmd_count_q != '0) && !m_busy && rsp_free) begin
                    {addr_d, len_d, tx_d} = cmd_head;
                    cmd_pop = 1'b1;
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (m_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            WAIT_DONE: if (!m_busy) state_d = SETTLE;
            SETTLE:    state_d = CAPTURE;
            CAPTURE: begin
                rsp_push = 1'b1;
                state_d  = IDLE;
            end
            default:   state_d = IDLE;
        endcase
        cmd_wr_ptr_d = cmd_wr_ptr_q + (CW+1)'(cmd_push);
        cmd_rd_ptr_d = cmd_rd_ptr_q + (CW+1)'(cmd_pop);
        cmd_count_d  = cmd_count_q + (CW+1)'(cmd_push) - (CW+1)'(cmd_pop);
        // Head-valid lags the count by a cycle so issue never races a same-cycle write.
        cmd_avail_d  = (cmd_count_q != '0);
    end

    always_comb begin
        case (len_q)
            2'd0:    rx_mask = 32'h0000_00FF;
            2'd1:    rx_mask = 32'h0000_FFFF;
            2'd2:    rx_mask = 32'h00FF_FFFF;
            default: rx_mask = 32'hFFFF_FFFF;
        endcase
        rx_masked = m_rx_data & rx_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_wr_ptr_q <= '0;
            cmd_rd_ptr_q <= '0;
            cmd_count_q  <= '0;
            cmd_avail_q  <= 1'b0;
            state_q      <= IDLE;
            start_q      <= 1'b0;
            tx_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            cmd_wr_ptr_q <= cmd_wr_ptr_d;
            cmd_rd_ptr_q <= cmd_rd_ptr_d;
            cmd_count_q  <= cmd_count_d;
            cmd_avail_q  <= cmd_avail_d;
            state_q      <= state_d;
            start_q      <= start_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem_q[cmd_wr_ptr_q[CW-1:0]] <= {cmd_addr, cmd_len, cmd_data};
    end

`ifdef SPI_SEQ_RSP_FIFO_EN
    localparam int RW = $clog2(RSP_DEPTH);
    localparam logic [RW:0] RSP_FULL = (RW+1)'(RSP_DEPTH);

    logic [RE-1:0] rsp_mem_q [RSP_DEPTH];
    logic [RW:0]   rsp_wr_ptr_q, rsp_wr_ptr_d, rsp_rd_ptr_q, rsp_rd_ptr_d, rsp_count_q, rsp_count_d;

    assign rsp_valid            = (rsp_count_q != '0);
    assign rsp_free             = (rsp_count_q != RSP_FULL) || rsp_ready;
    assign {rsp_addr, rsp_data} = rsp_valid ? rsp_mem_q[rsp_rd_ptr_q[RW-1:0]] : '0;

    always_comb begin
        rsp_wr_ptr_d = rsp_wr_ptr_q + (RW+1)'(rsp_push);
        rsp_rd_ptr_d = rsp_rd_ptr_q + (RW+1)'(rsp_pop);
        rsp_count_d  = rsp_count_q + (RW+1)'(rsp_push) - (RW+1)'(rsp_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_wr_ptr_q <= '0;
            rsp_rd_ptr_q <= '0;
            rsp_count_q  <= '0;
        end else begin
            rsp_wr_ptr_q <= rsp_wr_ptr_d;
            rsp_rd_ptr_q <= rsp_rd_ptr_d;
            rsp_count_q  <= rsp_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_push) rsp_mem_q[rsp_wr_ptr_q[RW-1:0]] <= {addr_q, rx_masked};
    end
`else
    logic          rsp_valid_q, rsp_valid_d;
    logic [RE-1:0] rsp_word_q, rsp_word_d;

    assign rsp_valid            = rsp_valid_q;
    assign rsp_free             = !rsp_valid_q || rsp_ready;
    assign {rsp_addr, rsp_data} = rsp_word_q;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_word_d  = rsp_word_q;
        if (rsp_pop) rsp_valid_d = 1'b0;
        if (rsp_push) begin
            rsp_valid_d = 1'b1;
            rsp_word_d  = {addr_q, rx_masked};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_word_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_word_q  <= rsp_word_d;
        end
    end
`endif

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Directed bench for spi_master_sequencer with a small behavioural spi_master stand-in.
module tb_spi_master_sequencer;
`ifdef SPI_SEQ_RSP_FIFO_EN
    localparam int RSP_EFF = 4;
`else
    localparam int RSP_EFF = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, start_trans, m_busy, err_timeout;
    logic [31:0] cmd_data, rsp_data, m_tx_data, m_rx_data;
    logic [2:0]  cmd_addr, rsp_addr, m_chipADDRS, cmd_count;
    logic [1:0]  cmd_len, m_transaction_length;

    logic model_busy, hold_busy = 1'b0, master_en = 1'b1;
    int   total = 0, bad = 0, cyc = 0, n_pulses = 0, pulse_cyc = 0, drop_cyc = 0, push_cyc = 0;
    int   busy_len = 4;
    logic [31:0] rx_q[$];
    logic [36:0] iss_q[$];

    assign m_busy = model_busy | hold_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .start_trans(start_trans), .m_busy(m_busy), .m_tx_data(m_tx_data),
        .m_chipADDRS(m_chipADDRS), .m_transaction_length(m_transaction_length),
        .m_rx_data(m_rx_data), .cmd_count(cmd_count), .err_timeout(err_timeout)
    );

    // Master stand-in: raises busy right after start_trans, returns the next queued rx word when done.
    initial begin
        model_busy = 1'b0;
        m_rx_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (start_trans) begin
                n_pulses++;
                pulse_cyc = cyc;
                iss_q.push_back({m_chipADDRS, m_transaction_length, m_tx_data});
                if (master_en) begin
                    model_busy = 1'b1;
                    repeat (busy_len) @(posedge clk);
                    #1;
                    m_rx_data  = (rx_q.size() != 0) ? rx_q.pop_front() : 32'h0;
                    model_busy = 1'b0;
                    drop_cyc   = cyc;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic push_cmd(input logic [2:0] a, input logic [1:0] l, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_data = d;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        if (!cmd_ready) check("push_ready_bound", {31'b0, cmd_ready}, 32'd1);
        tick();
        push_cyc  = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 300) begin tick(); n++; end
        if (!rsp_valid) check("rsp_wait_bound", {31'b0, rsp_valid}, 32'd1);
    endtask

    task automatic pop_rsp(input string tag, input logic [2:0] ea, input logic [31:0] ed);
        wait_rsp();
        check({tag, "_addr"}, {29'b0, rsp_addr}, {29'b0, ea});
        check({tag, "_data"}, rsp_data, ed);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, nbp;
        logic [36:0] e;
        logic [2:0]  t2_addr [4] = '{3'd1, 3'd3, 3'd5, 3'd7};
        logic [31:0] t2_tx   [4] = '{32'h11, 32'h2222, 32'h33_3333, 32'h4444_4444};
        logic [31:0] t2_exp  [4] = '{32'hDD, 32'hCCDD, 32'hBB_CCDD, 32'hAABB_CCDD};

        rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_data = '0; rsp_ready = 1'b0;
        tick(); tick();
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_addr", {29'b0, rsp_addr}, 32'd0);
        check("rst_cmd_count", {29'b0, cmd_count}, 32'd0);
        check("rst_err", {31'b0, err_timeout}, 32'd0);
        check("rst_start", {31'b0, start_trans}, 32'd0);
        check("rst_m_tx", m_tx_data, 32'd0);
        check("rst_m_chip", {29'b0, m_chipADDRS}, 32'd0);
        check("rst_m_len", {30'b0, m_transaction_length}, 32'd0);
        rst = 1'b1;
        tick();

        // Single 8-bit command
        rx_q.push_back(32'h0000_003C);
        push_cmd(3'd2, 2'd0, 32'hA5);
        wait_rsp();
        check("t1_rsp_latency", cyc - drop_cyc, 32'd3);
        check("t1_start_latency", pulse_cyc - push_cyc, 32'd2);
        check("t1_m_chip", {29'b0, m_chipADDRS}, 32'd2);
        check("t1_m_tx", m_tx_data, 32'hA5);
        pop_rsp("t1_rsp", 3'd2, 32'h0000_003C);
        check("t1_pulses", n_pulses, 32'd1);
        iss_q.delete();

        // Four queued commands, one per length code
        hold_busy = 1'b1;
        base = n_pulses;
        for (int i = 0; i < 4; i++) begin
            rx_q.push_back(32'hAABB_CCDD);
            push_cmd(t2_addr[i], 2'(i), t2_tx[i]);
        end
        check("t2_ready_full", {31'b0, cmd_ready}, 32'd0);
        check("t2_count_full", {29'b0, cmd_count}, 32'd4);
        cmd_valid = 1'b1; cmd_addr = 3'd0; cmd_len = 2'd0; cmd_data = 32'hFFFF;
        tick();
        cmd_valid = 1'b0;
        check("t2_push_while_full", {29'b0, cmd_count}, 32'd4);
        hold_busy = 1'b0;
        for (int i = 0; i < 4; i++) pop_rsp($sformatf("t2_rsp%0d", i), t2_addr[i], t2_exp[i]);
        check("t2_pulses", n_pulses - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            e = (iss_q.size() != 0) ? iss_q.pop_front() : '0;
            check($sformatf("t2_iss%0d", i), {e[36:34], e[33:32], e[26:0]},
                  {t2_addr[i], 2'(i), t2_tx[i][26:0]});
        end

        // Response back-pressure
        base = n_pulses;
        nbp  = RSP_EFF + 2;
        for (int i = 0; i < nbp; i++) begin
            rx_q.push_back(32'h100 + i);
            push_cmd(3'(i), 2'd3, 32'h1000 + i);
        end
        wait_cycles(60);
        check("t3_issued_held", n_pulses - base, RSP_EFF);
        check("t3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        pop_rsp("t3_rsp0", 3'd0, 32'h100);
        wait_cycles(60);
        check("t3_issued_after_pop", n_pulses - base, RSP_EFF + 1);
        for (int i = 1; i < nbp; i++) pop_rsp($sformatf("t3_rsp%0d", i), 3'(i), 32'h100 + i);
        check("t3_pulses", n_pulses - base, nbp);

        // Timeout: master never answers
        master_en = 1'b0;
        base = n_pulses;
        push_cmd(3'd4, 2'd3, 32'h1234_5678);
        n = 0;
        while (!err_timeout && n < 100) begin tick(); n++; end
        check("t4_err", {31'b0, err_timeout}, 32'd1);
        check("t4_err_latency", cyc - pulse_cyc, 32'd16);
        wait_cycles(5);
        check("t4_no_rsp", {31'b0, rsp_valid}, 32'd0);
        master_en = 1'b1;
        rx_q.push_back(32'h5555_1234);
        push_cmd(3'd6, 2'd1, 32'hBEEF);
        pop_rsp("t4_next", 3'd6, 32'h0000_1234);
        check("t4_pulses", n_pulses - base, 32'd2);
        check("t4_err_sticky", {31'b0, err_timeout}, 32'd1);

        // Reset during WAIT_DONE with two commands still queued
        busy_len  = 20;
        hold_busy = 1'b1;
        base = n_pulses;
        push_cmd(3'd1, 2'd0, 32'h1);
        push_cmd(3'd2, 2'd0, 32'h2);
        push_cmd(3'd3, 2'd0, 32'h3);
        rx_q.push_back(32'h77);
        hold_busy = 1'b0;
        n = 0;
        while (n_pulses == base && n < 50) begin tick(); n++; end
        check("t5_issued", n_pulses - base, 32'd1);
        wait_cycles(4);
        check("t5_count_before", {29'b0, cmd_count}, 32'd2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t5_count_rst", {29'b0, cmd_count}, 32'd0);
        check("t5_err_clr", {31'b0, err_timeout}, 32'd0);
        check("t5_rsp_rst", {31'b0, rsp_valid}, 32'd0);
        base = n_pulses;
        rx_q.push_back(32'h1122_3344);
        push_cmd(3'd5, 2'd2, 32'hC0FFEE);
        n = 0;
        while (n_pulses == base && n < 100) begin tick(); n++; end
        check("t5_issue_after_busy", pulse_cyc - drop_cyc, 32'd1);
        pop_rsp("t5_new", 3'd5, 32'h0022_3344);
        check("t5_pulses", n_pulses - base, 32'd1);
        busy_len = 4;

        // Push and IDLE->START on the same edge
        hold_busy = 1'b1;
        rx_q.push_back(32'hA1); rx_q.push_back(32'hA2); rx_q.push_back(32'hA3);
        push_cmd(3'd1, 2'd0, 32'h1);
        push_cmd(3'd2, 2'd0, 32'h2);
        tick(); tick();
        check("t6_count_pre", {29'b0, cmd_count}, 32'd2);
        cmd_valid = 1'b1; cmd_addr = 3'd3; cmd_len = 2'd0; cmd_data = 32'h3;
        hold_busy = 1'b0;
        tick();
        cmd_valid = 1'b0;
        check("t6_start", {31'b0, start_trans}, 32'd1);
        check("t6_count_same", {29'b0, cmd_count}, 32'd2);
        pop_rsp("t6_rsp0", 3'd1, 32'hA1);
        pop_rsp("t6_rsp1", 3'd2, 32'hA2);
        pop_rsp("t6_rsp2", 3'd3, 32'hA3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_master_sequencer.md
# spi_master_sequencer

Command-queue front end that sits directly upstream of `spi_master` and feeds it transactions. Buffers SPI commands (chip address, length, TX word) in a FIFO and issues them one at a time through the master's `start_trans`/`busy` handshake. Captures each completed `rx_data` word into a response FIFO. Lets a host or bus bridge post back-to-back transfers without polling `busy`.

## Interface
Parameters:
- `SLAVE_ADDRS_LEN`, 3: width of the chip address; must match the attached `spi_master`.
- `CMD_DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `RSP_DEPTH`, 4: response FIFO entries; power of two, at least 2.
- `TIMEOUT`, 15: cycles to wait for `m_busy` to rise after `start_trans`; range 2–255.

Ports:
- `clk`  in  1  system clock; same clock as `spi_master`.
- `rst`  in  1  reset; **one clock; reset is synchronous and active-low**.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command FIFO not full.
- `cmd_data`  in  32  TX word, right-aligned.
- `cmd_addr`  in  SLAVE_ADDRS_LEN  target chip.
- `cmd_len`  in  2  length code: 0 = 8b, 1 = 16b, 2 = 24b, 3 = 32b.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  32  received word, masked to its length.
- `rsp_addr`  out  SLAVE_ADDRS_LEN  chip the response came from.
- `start_trans`  out  1  to master; one-cycle pulse.
- `m_busy`  in  1  from master `busy`.
- `m_tx_data`  out  32  to master `tx_data`.
- `m_chipADDRS`  out  SLAVE_ADDRS_LEN  to master `chipADDRS`.
- `m_transaction_length`  out  2  to master `transaction_length`.
- `m_rx_data`  in  32  from master `rx_data`.
- `cmd_count`  out  $clog2(CMD_DEPTH)+1  number of queued commands.
- `err_timeout`  out  1  sticky; cleared only by reset.

## Operation
- Handshake on both FIFO ports: a transfer happens when valid and ready are both high on a `clk` edge.
- Command push and pop may happen in the same cycle; `cmd_count` is then unchanged.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, SETTLE, CAPTURE.
- **IDLE → START** when the command FIFO is non-empty, `m_busy` = 0, and the response FIFO has a free slot (counting any slot freed by a pop in the same cycle). On this edge:
  - `m_tx_data`, `m_chipADDRS` and `m_transaction_length` are loaded from the FIFO head.
  - The head entry is popped.
- **START**: `start_trans` = 1 for exactly this cycle. Next state is WAIT_BUSY, and the timeout counter is cleared.
- **WAIT_BUSY**:
  - `m_busy` = 1 → WAIT_DONE.
  - Counter reaches TIMEOUT → set `err_timeout`, drop the command with no response, go to IDLE.
- **WAIT_DONE**: `m_busy` = 0 → SETTLE.
- **SETTLE**: one cycle. This lets the master's `rx_data` update, which happens when the master leaves its post-transfer state, settle before sampling.
- **CAPTURE**: push `{addr, m_rx_data & mask}` into the response FIFO → IDLE.
  - Mask per length code: 0x000000FF, 0x0000FFFF, 0x00FFFFFF, 0xFFFFFFFF.
- `m_*` outputs hold stable from START until the next IDLE→START.
- Reset values:
  - All `m_*` outputs = 0; `start_trans` = 0.
  - `cmd_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0, `rsp_addr` = 0.
  - `cmd_count` = 0, `err_timeout` = 0, FSM in IDLE, both FIFOs empty.
- Reset mid-transfer: both FIFOs are flushed and the FSM returns to IDLE. The master is not reset by this block. After reset, IDLE waits for `m_busy` = 0 before issuing.
- Full and empty behaviour:
  - Push while full is ignored (`cmd_ready` is low).
  - `rsp_valid` = 0 when the response FIFO is empty.
  - Pointers wrap modulo depth; counts use one extra bit.

## Timing
- `cmd_valid` accepted at edge N with the sequencer idle, master idle and FIFO previously empty:
  - Entry visible at N+1.
  - IDLE→START at N+2 edge; `start_trans` high in cycle N+2..N+3.
- Response latency: `rsp_valid` rises 2 edges after the edge on which `m_busy` is sampled low in WAIT_DONE (SETTLE, then CAPTURE).
- Minimum gap between consecutive `start_trans` pulses: master transfer time + 4 cycles.
- Response FIFO output is first-word-fall-through: `rsp_data`/`rsp_addr` are valid whenever `rsp_valid` = 1.

## Configuration
- `SPI_SEQ_RSP_FIFO_EN` defined: response FIFO of depth RSP_DEPTH as described above.
- Not defined: the response path is a single holding register (effective depth 1).
  - `rsp_valid` sets on CAPTURE and clears on `rsp_ready`.
  - IDLE→START requires the register to be empty or popped in the same cycle.
  - RSP_DEPTH is ignored.

## Test plan
- Reset, single command: 8-bit, addr 2, data 0xA5, slave returns 0x3C → one `start_trans` pulse, `m_chipADDRS` = 2; response `rsp_data` = 0x0000003C, `rsp_addr` = 2.
- Queue depth: push 4 commands back-to-back with lengths 0/1/2/3 → `cmd_ready` low after the 4th push. Exactly 4 pulses, issued in order; responses masked 0xFF / 0xFFFF / 0xFFFFFF / full, in order.
- Response back-pressure: hold `rsp_ready` = 0 and push 6 commands → only RSP_DEPTH transfers issue. After 1 pop, exactly one more transfer issues.
- Timeout: tie `m_busy` = 0 and push 1 command → `err_timeout` = 1 after 15 WAIT_BUSY cycles, no response, FSM back in IDLE, next command still issued.
- Reset mid-transfer: assert `rst` low during WAIT_DONE with 2 commands queued → `cmd_count` = 0, no response, `start_trans` stays low until `m_busy` = 0 and a new push arrives.
- Simultaneous push and pop: `cmd_count` = 2 with push and IDLE→START on the same edge → `cmd_count` stays 2.
